// File: rtl/gamma_lut_ctrl.sv
// gamma_lut_ctrl: runtime-programmable gamma stage with ping-pong 2^DW_IN x DW_OUT tables.
// The pixel path reads the active bank, and the host loads the shadow bank.
// A commit swaps the banks at the next frame start, so one frame never mixes two curves.
// After reset both banks are filled with an identity curve, one address per cycle.
// Optional macro GAMMA_LUT_CTRL_READBACK_EN adds a 1-cycle shadow-bank readback port.
// The identity curve replicates the top input bits into the low output bits.
// This assumes 0 < DW_OUT-DW_IN <= DW_IN.
module gamma_lut_ctrl #(
  parameter int DW_IN  = 8,
  parameter int DW_OUT = 12
) (
  input  logic              I_clk,
  input  logic              I_rst,
  input  logic              I_vs,
  input  logic              I_pix_valid,
  input  logic [DW_IN-1:0]  I_pix_data,
  output logic              O_pix_valid,
  output logic [DW_OUT-1:0] O_pix_data,
  input  logic              I_wr_en,
  input  logic [DW_IN-1:0]  I_wr_addr,
  input  logic [DW_OUT-1:0] I_wr_data,
  output logic              O_wr_ready,
  input  logic              I_commit,
  output logic              O_swap_pend,
  output logic              O_swap_done,
  output logic              O_init_busy,
  output logic              O_active_bank,
  output logic [DW_IN:0]    O_wr_cnt
`ifdef GAMMA_LUT_CTRL_READBACK_EN
  ,
  input  logic              I_rd_en,
  input  logic [DW_IN-1:0]  I_rd_addr,
  output logic              O_rd_valid,
  output logic [DW_OUT-1:0] O_rd_data
`endif
);

  localparam int              DEPTH    = 1 << DW_IN;
  localparam logic [DW_IN-1:0] ADDR_MAX = '1;
  localparam logic [DW_IN-1:0] ADDR_ONE = 1;
  localparam logic [DW_IN:0]   CNT_MAX  = {1'b1, {DW_IN{1'b0}}};
  localparam logic [DW_IN:0]   CNT_ONE  = 1;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_PEND = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic [DW_IN-1:0]    r_fillCnt;
  logic                r_vs;
  logic                w_vsRise;
  logic                r_activeBank;
  logic                r_swapDone;
  logic [DW_IN:0]      r_wrCnt;
  logic                w_fillWr;
  logic                w_hostWr;
  logic                w_swap;

  logic [DW_OUT-1:0]   r_bank0 [DEPTH];
  logic [DW_OUT-1:0]   r_bank1 [DEPTH];

  logic                r_s1Valid;
  logic [DW_IN-1:0]    r_s1Addr;
  logic                r_s1Bank;
  logic                r_s1Bypass;
  logic                r_s2Valid;
  logic [DW_OUT-1:0]   r_s2Data;
  logic [DW_OUT-1:0]   w_tableRd;

  function automatic logic [DW_OUT-1:0] identity(input logic [DW_IN-1:0] a);
    return {a, a[DW_IN-1 -: DW_OUT-DW_IN]};
  endfunction

  assign w_vsRise      = I_vs & ~r_vs;
  assign O_init_busy   = (r_state == ST_INIT);
  assign O_wr_ready    = (r_state == ST_IDLE);
  assign O_swap_pend   = (r_state == ST_PEND);
  assign O_swap_done   = r_swapDone;
  assign O_active_bank = r_activeBank;
  assign O_wr_cnt      = r_wrCnt;
  assign O_pix_valid   = r_s2Valid;
  assign O_pix_data    = r_s2Data;

  // Next-state and per-cycle control strobes; INIT ignores host and vs activity.
  always_comb begin
    w_nextState = r_state;
    w_fillWr    = 1'b0;
    w_hostWr    = 1'b0;
    w_swap      = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_fillWr = 1'b1;
        if (r_fillCnt == ADDR_MAX) w_nextState = ST_IDLE;
      end
      ST_IDLE: begin
        w_hostWr = I_wr_en;
        if (I_commit) w_nextState = ST_PEND;
      end
      ST_PEND: begin
        if (w_vsRise) begin
          w_swap      = 1'b1;
          w_nextState = ST_IDLE;
        end
      end
      default: w_nextState = ST_INIT;
    endcase
  end

  // State register; reset always restarts the identity fill.
  always_ff @(posedge I_clk) begin
    if (I_rst) r_state <= ST_INIT;
    else       r_state <= w_nextState;
  end

  // Identity fill address, one entry per INIT cycle.
  always_ff @(posedge I_clk) begin
    if (I_rst)         r_fillCnt <= '0;
    else if (w_fillWr) r_fillCnt <= r_fillCnt + ADDR_ONE;
  end

  // Previous frame-sync level for rising-edge detection.
  always_ff @(posedge I_clk) begin
    if (I_rst) r_vs <= 1'b0;
    else       r_vs <= I_vs;
  end

  // Bank select, swap pulse and the saturating write counter since the last swap.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      r_activeBank <= 1'b0;
      r_swapDone   <= 1'b0;
      r_wrCnt      <= '0;
    end else begin
      r_swapDone <= w_swap;
      if (w_swap) begin
        r_activeBank <= ~r_activeBank;
        r_wrCnt      <= '0;
      end else if (w_hostWr && (r_wrCnt != CNT_MAX)) begin
        r_wrCnt <= r_wrCnt + CNT_ONE;
      end
    end
  end

  // Table storage: identity fill hits both banks, host writes only touch the shadow bank.
  always_ff @(posedge I_clk) begin
    if (!I_rst) begin
      if (w_fillWr) begin
        r_bank0[r_fillCnt] <= identity(r_fillCnt);
        r_bank1[r_fillCnt] <= identity(r_fillCnt);
      end else if (w_hostWr) begin
        if (r_activeBank) r_bank0[I_wr_addr] <= I_wr_data;
        else              r_bank1[I_wr_addr] <= I_wr_data;
      end
    end
  end

  // Pixel stage 1: capture address, valid, bank snapshot and whether the tables are still filling.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      r_s1Valid  <= 1'b0;
      r_s1Addr   <= '0;
      r_s1Bank   <= 1'b0;
      r_s1Bypass <= 1'b0;
    end else begin
      r_s1Valid  <= I_pix_valid;
      r_s1Addr   <= I_pix_data;
      r_s1Bank   <= r_activeBank;
      r_s1Bypass <= (r_state == ST_INIT);
    end
  end

  // Table read for the snapshotted bank, or the arithmetic identity while tables are filling.
  always_comb begin
    w_tableRd = identity(r_s1Addr);
    if (!r_s1Bypass) begin
      if (r_s1Bank) w_tableRd = r_bank1[r_s1Addr];
      else          w_tableRd = r_bank0[r_s1Addr];
    end
  end

  // Pixel stage 2: register the corrected pixel; data holds while no pixel is present.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      r_s2Valid <= 1'b0;
      r_s2Data  <= '0;
    end else begin
      r_s2Valid <= r_s1Valid;
      if (r_s1Valid) r_s2Data <= w_tableRd;
    end
  end

`ifdef GAMMA_LUT_CTRL_READBACK_EN
  logic              r_rdValid;
  logic [DW_OUT-1:0] r_rdData;
  logic              w_rdAccept;

  assign w_rdAccept = I_rd_en && (r_state != ST_INIT);
  assign O_rd_valid = r_rdValid;
  assign O_rd_data  = r_rdData;

  // Shadow-bank readback with one cycle of latency; requests during the fill are dropped.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      r_rdValid <= 1'b0;
      r_rdData  <= '0;
    end else begin
      r_rdValid <= w_rdAccept;
      if (w_rdAccept) begin
        if (r_activeBank) r_rdData <= r_bank0[I_rd_addr];
        else              r_rdData <= r_bank1[I_rd_addr];
      end
    end
  end
`endif

endmodule

// File: tb/tb_gamma_lut_ctrl.sv
// Testbench for gamma_lut_ctrl: directed scenarios plus a randomized phase.
// A curve-level reference model predicts every output, and a negedge process compares each cycle.
module tb_gamma_lut_ctrl;

  localparam int DW_IN  = 8;
  localparam int DW_OUT = 12;
  localparam int DEPTH  = 256;

  logic              I_clk = 1'b0;
  logic              I_rst = 1'b1;
  logic              I_vs = 1'b0;
  logic              I_pix_valid = 1'b0;
  logic [DW_IN-1:0]  I_pix_data = '0;
  logic              O_pix_valid;
  logic [DW_OUT-1:0] O_pix_data;
  logic              I_wr_en = 1'b0;
  logic [DW_IN-1:0]  I_wr_addr = '0;
  logic [DW_OUT-1:0] I_wr_data = '0;
  logic              O_wr_ready;
  logic              I_commit = 1'b0;
  logic              O_swap_pend;
  logic              O_swap_done;
  logic              O_init_busy;
  logic              O_active_bank;
  logic [DW_IN:0]    O_wr_cnt;
`ifdef GAMMA_LUT_CTRL_READBACK_EN
  logic              I_rd_en = 1'b0;
  logic [DW_IN-1:0]  I_rd_addr = '0;
  logic              O_rd_valid;
  logic [DW_OUT-1:0] O_rd_data;
`endif

  gamma_lut_ctrl #(.DW_IN(DW_IN), .DW_OUT(DW_OUT)) dut (
    .I_clk(I_clk), .I_rst(I_rst), .I_vs(I_vs),
    .I_pix_valid(I_pix_valid), .I_pix_data(I_pix_data),
    .O_pix_valid(O_pix_valid), .O_pix_data(O_pix_data),
    .I_wr_en(I_wr_en), .I_wr_addr(I_wr_addr), .I_wr_data(I_wr_data),
    .O_wr_ready(O_wr_ready), .I_commit(I_commit),
    .O_swap_pend(O_swap_pend), .O_swap_done(O_swap_done),
    .O_init_busy(O_init_busy), .O_active_bank(O_active_bank),
    .O_wr_cnt(O_wr_cnt)
`ifdef GAMMA_LUT_CTRL_READBACK_EN
    ,
    .I_rd_en(I_rd_en), .I_rd_addr(I_rd_addr),
    .O_rd_valid(O_rd_valid), .O_rd_data(O_rd_data)
`endif
  );

  always #5 I_clk = ~I_clk;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state: two curves, which one is live, and the pending-swap flag.
  bit          mKnown = 1'b0;
  bit          mInit;
  int          mInitLeft;
  bit          mPend;
  bit          mBank;
  int          mCnt;
  bit          mVsPrev;
  bit          vsRise;
  logic [11:0] mTab [2][DEPTH];
  bit          p1Valid;
  logic [11:0] p1Data;
  bit          eValid;
  logic [11:0] eData;
  bit          eSwap;
  bit          eRdValid;
  logic [11:0] eRdData;

  function automatic logic [11:0] identVal(input int a);
    return 12'((a * 16) + (a / 16));
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model update on each rising edge from the inputs the DUT also sees.
  always @(posedge I_clk) begin
    if (I_rst) begin
      mKnown = 1'b1; mInit = 1'b1; mInitLeft = DEPTH; mPend = 1'b0; mBank = 1'b0;
      mCnt = 0; mVsPrev = 1'b0; p1Valid = 1'b0; p1Data = '0; eValid = 1'b0;
      eData = '0; eSwap = 1'b0; eRdValid = 1'b0; eRdData = '0;
    end else if (mKnown) begin
`ifdef GAMMA_LUT_CTRL_READBACK_EN
      eRdValid = I_rd_en && !mInit;
      if (eRdValid) eRdData = mTab[!mBank][I_rd_addr];
`endif
      eValid = p1Valid;
      if (p1Valid) eData = p1Data;
      p1Valid = I_pix_valid;
      if (I_pix_valid) p1Data = mInit ? identVal(int'(I_pix_data)) : mTab[mBank][I_pix_data];
      eSwap   = 1'b0;
      vsRise  = I_vs && !mVsPrev;
      mVsPrev = I_vs;
      if (mInit) begin
        mInitLeft--;
        if (mInitLeft == 0) begin
          mInit = 1'b0;
          for (int a = 0; a < DEPTH; a++) begin
            mTab[0][a] = identVal(a);
            mTab[1][a] = identVal(a);
          end
        end
      end else if (!mPend) begin
        if (I_wr_en) begin
          mTab[!mBank][I_wr_addr] = I_wr_data;
          if (mCnt < DEPTH) mCnt++;
        end
        if (I_commit) mPend = 1'b1;
      end else if (vsRise) begin
        mBank = !mBank;
        eSwap = 1'b1;
        mCnt  = 0;
        mPend = 1'b0;
      end
    end
  end

  // Compare every DUT output against the model midway through each cycle.
  always @(negedge I_clk) begin
    if (mKnown) begin
      checkOutput("init_busy",   O_init_busy,   mInit);
      checkOutput("wr_ready",    O_wr_ready,    !mInit && !mPend);
      checkOutput("swap_pend",   O_swap_pend,   mPend);
      checkOutput("swap_done",   O_swap_done,   eSwap);
      checkOutput("active_bank", O_active_bank, mBank);
      checkOutput("wr_cnt",      O_wr_cnt,      mCnt);
      checkOutput("pix_valid",   O_pix_valid,   eValid);
      checkOutput("pix_data",    O_pix_data,    eData);
`ifdef GAMMA_LUT_CTRL_READBACK_EN
      checkOutput("rd_valid",    O_rd_valid,    eRdValid);
      if (eRdValid) checkOutput("rd_data", O_rd_data, eRdData);
`endif
    end
  end

  // One clock cycle with the given inputs; returns 1 ns after the edge that sampled them.
  task automatic applyStimulus(input bit rst, input bit vs, input bit pv, input logic [7:0] pd,
                               input bit we, input logic [7:0] wa, input logic [11:0] wd,
                               input bit commit);
    I_rst = rst; I_vs = vs; I_pix_valid = pv; I_pix_data = pd;
    I_wr_en = we; I_wr_addr = wa; I_wr_data = wd; I_commit = commit;
`ifdef GAMMA_LUT_CTRL_READBACK_EN
    I_rd_en = 1'($urandom_range(0, 1)); I_rd_addr = 8'($urandom);
`endif
    @(posedge I_clk);
    #1;
  endtask

  task automatic idleCycle(input bit vs);
    applyStimulus(1'b0, vs, 1'b0, 8'h00, 1'b0, 8'h00, 12'h000, 1'b0);
  endtask

  int n;
  bit vsLevel;

  initial begin
    // Reset state.
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 12'h000, 1'b0);
    checkOutput("rst_init_busy", O_init_busy, 1);
    checkOutput("rst_wr_cnt", O_wr_cnt, 0);
    checkOutput("rst_bank", O_active_bank, 0);
    checkOutput("rst_pix_valid", O_pix_valid, 0);

    // Fill length, with an identity-bypassed pixel during the fill.
    n = 0;
    while (O_init_busy === 1'b1 && n < 1000) begin
      applyStimulus(1'b0, 1'b0, (n == 0), 8'h80, 1'b0, 8'h00, 12'h000, 1'b0);
      if (n == 1) checkOutput("init_bypass_0x80", O_pix_data, 12'h808);
      n++;
    end
    checkOutput("init_len", n, 256);
    checkOutput("wr_ready_after_init", O_wr_ready, 1);

    // Identity table lookup after the fill.
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h80, 1'b0, 8'h00, 12'h000, 1'b0);
    idleCycle(1'b0);
    checkOutput("table_0x80", O_pix_data, 12'h808);

    // Load one entry, commit, then swap on frame start.
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h10, 12'hABC, 1'b0);
    checkOutput("wr_cnt_one", O_wr_cnt, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 12'h000, 1'b1);
    checkOutput("pend_after_commit", O_swap_pend, 1);
    idleCycle(1'b1);
    checkOutput("swap_done_pulse", O_swap_done, 1);
    checkOutput("bank_after_swap", O_active_bank, 1);
    checkOutput("wr_cnt_cleared", O_wr_cnt, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h10, 1'b0, 8'h00, 12'h000, 1'b0);
    checkOutput("swap_done_once", O_swap_done, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 8'h00, 12'h000, 1'b0);
    checkOutput("new_curve_0x10", O_pix_data, 12'hABC);
    idleCycle(1'b0);
    checkOutput("kept_identity_0x11", O_pix_data, 12'h111);

    // Writes while pending are ignored.
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 12'h000, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h20, 12'h123, 1'b0);
    checkOutput("pend_wr_ready", O_wr_ready, 0);
    checkOutput("pend_wr_cnt", O_wr_cnt, 0);
    idleCycle(1'b1);
    checkOutput("bank_back_to_0", O_active_bank, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h20, 1'b0, 8'h00, 12'h000, 1'b0);
    idleCycle(1'b0);
    checkOutput("ignored_write_0x20", O_pix_data, 12'h202);

    // Commit coinciding with a vs edge waits for the following edge.
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h30, 12'h555, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 12'h000, 1'b1);
    checkOutput("same_cycle_no_swap", O_active_bank, 0);
    checkOutput("same_cycle_pend", O_swap_pend, 1);
    idleCycle(1'b0);
    idleCycle(1'b1);
    checkOutput("next_edge_swap", O_active_bank, 1);
    checkOutput("next_edge_cnt", O_wr_cnt, 0);
    idleCycle(1'b0);

    // Counter saturation, then a continuous pixel stream across the swap.
    for (int i = 0; i < 300; i++)
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'($urandom), 12'($urandom), 1'b0);
    checkOutput("wr_cnt_saturated", O_wr_cnt, 256);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'($urandom), 1'b0, 8'h00, 12'h000, 1'b1);
    for (int i = 0; i < 30; i++)
      applyStimulus(1'b0, (i == 10), 1'b1, 8'($urandom), 1'b0, 8'h00, 12'h000, 1'b0);

    // Reset while pending with pixels in flight.
    applyStimulus(1'b0, 1'b0, 1'b1, 8'($urandom), 1'b0, 8'h00, 12'h000, 1'b1);
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b0, 1'b0, 1'b1, 8'($urandom), 1'b0, 8'h00, 12'h000, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'($urandom), 1'b0, 8'h00, 12'h000, 1'b0);
    checkOutput("midrst_pix_valid", O_pix_valid, 0);
    checkOutput("midrst_swap_pend", O_swap_pend, 0);
    checkOutput("midrst_bank", O_active_bank, 0);
    checkOutput("midrst_init_busy", O_init_busy, 1);

    // Randomized traffic with occasional commits, frame syncs and resets.
    vsLevel = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 24) == 0) vsLevel = !vsLevel;
      applyStimulus(($urandom_range(0, 1499) == 0), vsLevel,
                    ($urandom_range(0, 3) != 0), 8'($urandom),
                    1'($urandom_range(0, 1)), 8'($urandom), 12'($urandom),
                    ($urandom_range(0, 39) == 0));
    end
    idleCycle(1'b0);
    idleCycle(1'b0);
    idleCycle(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
